// File: rtl/stream_fifo.sv
// stream_fifo: single-clock FIFO with valid/ready handshakes on both sides.
// Any depth of 2 or more is allowed, not only powers of two. It provides an occupancy
// count, almost-full and almost-empty flags, a synchronous flush and a peak-occupancy
// monitor.
//
// Optional feature macro: STREAM_FIFO_FULL_PUSH_EN. When it is defined, a full FIFO
// accepts a write in the same cycle as a read. This adds a combinational path from
// out_ready_i to in_ready_o.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset; takes priority over flush_i
//   flush_i        synchronous clear of contents, pointers, count and peak
//   in_data_i      write data
//   in_valid_i     producer offers in_data_i
//   in_ready_o     FIFO accepts a write this cycle
//   out_data_o     head entry (don't-care while out_valid_o = 0)
//   out_valid_o    head entry present
//   out_ready_i    consumer takes the head entry
//   count_o        occupancy, 0..Depth
//   almost_full_o  count_o >= AfThr
//   almost_empty_o count_o <= AeThr
//   peak_o         maximum count_o since the last reset or flush
module stream_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 6,
   parameter int unsigned AfThr = Depth - 1,
   parameter int unsigned AeThr = 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic [Width-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [Width-1:0] out_data_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [CntW-1:0]  count_o,
   output logic             almost_full_o,
   output logic             almost_empty_o,
   output logic [CntW-1:0]  peak_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW-1:0] PtrMax = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [CntW-1:0]  peak_q, peak_d;

   logic full, empty, clear, wr_en, rd_en;

   assign full  = (count_q == CntFull);
   assign empty = (count_q == '0);
   assign clear = reset_i | flush_i;

   // A reset or flush cycle blocks both handshakes, so no word crosses the clear.
`ifdef STREAM_FIFO_FULL_PUSH_EN
   assign in_ready_o = (~full | out_ready_i) & ~clear;
`else
   assign in_ready_o = ~full & ~clear;
`endif
   assign out_valid_o = ~empty & ~clear;

   assign wr_en = in_valid_i & in_ready_o;
   assign rd_en = out_valid_o & out_ready_i;

   assign out_data_o     = mem_q[rd_ptr_q];
   assign count_o        = count_q;
   assign peak_o         = peak_q;
   assign almost_full_o  = (count_q >= CntW'(AfThr));
   assign almost_empty_o = (count_q <= CntW'(AeThr));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      peak_d   = peak_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         peak_d   = '0;
      end else begin
         // Pointers wrap by explicit compare, so the depth need not be a power of two.
         if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
         end
         unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
         if (count_d > peak_q) begin
            peak_d = count_d;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         peak_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         peak_q   <= peak_d;
      end
   end

   // Storage is deliberately not reset; entries are only visible through count_q.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Synchronous single-clock FIFO with valid/ready handshakes on both sides, arbitrary (non-power-of-two) depth, occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and a peak-occupancy monitor. It is the general-purpose buffer for AXI channel decoupling in the register-slave datapath, and the successor to the plain push/pop FIFO.

## Interface
- `Width`, 32: data bits per entry.
- `Depth`, 6: number of entries, any integer ≥ 2 (power of two not required).
- `AfThr`, `Depth-1`: `almost_full` asserts when count ≥ `AfThr` (legal range 1..`Depth`).
- `AeThr`, 1: `almost_empty` asserts when count ≤ `AeThr` (legal range 0..`Depth-1`).
- Derived `CntW` = `$clog2(Depth+1)`.
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear of contents.
- `in_data` in `Width`: write data.
- `in_valid` in 1: producer offers `in_data`.
- `in_ready` out 1: FIFO accepts; the write handshake is `in_valid & in_ready`.
- `out_data` out `Width`: head entry.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: consumer takes; the read handshake is `out_valid & out_ready`.
- `count` out `CntW`: current occupancy, 0..`Depth`.
- `almost_full`, `almost_empty` out 1: threshold flags.
- `peak` out `CntW`: maximum `count` since the last reset or flush.

## Operation
- Storage: `Depth`-entry register array, not reset. Write pointer and read pointer each range 0..`Depth-1` and wrap from `Depth-1` to 0 (explicit compare, no modulo-2^n).
- Full/empty are derived from `count`, not from pointer laps:
  - full = (`count` == `Depth`).
  - empty = (`count` == 0).
- Write handshake: store `in_data` at the write pointer and advance the write pointer.
- Read handshake: advance the read pointer.
- `count` next value is `count` + write − read. A simultaneous write and read leaves `count` unchanged.
- `out_valid` = !empty & !flush & !reset.
- `out_data` = array[read pointer], combinational. Its value is don't-care while `out_valid` = 0.
- `in_ready` = !full & !flush & !reset. This is extended by the configuration macro below.
- `almost_full` and `almost_empty` are combinational compares of the registered `count` against the thresholds.
- `peak` updates to next-`count` whenever next-`count` > `peak`.
- `flush`, while high:
  - The next edge sets both pointers, `count` and `peak` to 0.
  - No handshake completes in a flush cycle, because `in_ready` and `out_valid` are forced to 0.
- `reset` behaves exactly as `flush` and has priority over it.
- `reset` or `flush` mid-stream discards all stored data. No partial entry survives.

## Timing
- Reset values, and the values during any reset cycle:
  - `in_ready` = 0, `out_valid` = 0.
  - `count` = 0, `peak` = 0.
  - `almost_empty` = 1 (when `AeThr` ≥ 0).
  - `almost_full` = 0.
- On the first cycle after `reset` deasserts, `in_ready` = 1.
- Write-to-read latency is 1 cycle. A word written at edge N is visible with `out_valid` = 1 after edge N and can be read in cycle N+1. There is no same-cycle fall-through when empty.
- When empty with a write and `out_ready` = 1 in the same cycle, only the write completes.
- Full and no read pending: `in_ready` = 0 and `in_data` is ignored.
- Holding rules:
  - `out_data` is stable while `out_valid` = 1 and `out_ready` = 0.
  - `out_valid` never drops without a read handshake, a flush or a reset.
- Sustained throughput is 1 word/cycle with simultaneous write and read at any occupancy 1..`Depth-1`.
- Pointer wrap: with `Depth` = 6, write pointer sequence 4, 5, 0, 1, …

## Configuration
- `STREAM_FIFO_FULL_PUSH_EN` defined:
  - `in_ready` = (!full | out_ready) & !flush & !reset.
  - When full and a read completes in the same cycle, the write is accepted into the freed slot, `count` stays `Depth`, and throughput stays 1 word/cycle at full.
  - This introduces a combinational path from `out_ready` to `in_ready`.
- Macro not defined: `in_ready` depends only on registered state, `flush` and `reset`. A full FIFO refuses writes for the cycle in which a read occurs, and `in_ready` rises on the following cycle.

## Test plan
- Reset then fill (Depth=6): write 0xA0..0xA5 back-to-back with `out_ready` = 0.
  - `count` goes 1..6.
  - `in_ready` = 0 after the 6th write.
  - `almost_full` rises when `count` = 5.
  - `peak` = 6.
- Drain in order: `out_ready` = 1.
  - Outputs are 0xA0..0xA5 on consecutive cycles.
  - `out_valid` = 0 after the 6th read.
  - `almost_empty` rises when `count` = 1.
  - `peak` remains 6.
- Wrap-around streaming: 20 words with both sides always valid/ready, starting from `count` = 3. Data order is preserved across pointer wraps at 5→0, and `count` stays 3 throughout.
- Full with simultaneous read:
  - Macro on: `count` stays 6 and the new word appears after the five older ones.
  - Macro off: the write stalls one cycle and `count` goes 6→5→6.
- Flush mid-stream at `count` = 4 with `in_valid` = 1:
  - Next cycle: `count` = 0, `peak` = 0, `out_valid` = 0.
  - The flush-cycle word is not stored.
  - A later write of 0x55 is read back as 0x55.
- Reset during a burst at `count` = 2: all outputs take their reset values next cycle, and no stale data is ever presented with `out_valid` = 1.
